xor_share_arb: RTL

Round-robin arbiter and sequencer that shares one 1-bit XOR cell between two requesters. Each requester submits an operand pair (a, b) over a valid/ready handshake. The block grants one requester, streams the pair LSB-first through the shared cell over W cycles, and returns the W-bit result a^b tagged with the requester ID on a valid/ready response port. It sits between the requester logic and the bit-serial XOR datapath, and it is the only agent allowed to drive that cell.

---
 rtl/xor_share_pkg.sv | 7 +
 rtl/xor_bit_cell.sv | 9 +
 rtl/xor_share_arb.sv | 108 ++++++++++
 3 files changed

// File: rtl/xor_share_pkg.sv
// Shared types for the xor_share_arb codebase slice.
package xor_share_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef logic req_id_t;
   // last_id reset value: requester 0 wins the first tie.
   localparam req_id_t ID_RST = 1'b1;
endpackage

// File: rtl/xor_bit_cell.sv
// Shared 1-bit XOR cell, the resource being arbitrated.
// Purely combinational, no latency, no backpressure.
module xor_bit_cell (
   input  logic x,
   input  logic y,
   output logic z
);
   assign z = x ^ y;
endmodule

// File: rtl/xor_share_arb.sv
// Round-robin arbiter streaming one of two operand pairs LSB-first through a shared XOR cell.
// Latency: W cycles from the accept edge to rsp_valid; minimum issue period W+2.
// Backpressure: response held in DONE until rsp_ready; no request accepted while busy.
module xor_share_arb
   import xor_share_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_data,
   output logic         busy
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   state_t        state, state_nxt;
   req_id_t       last_id, id, grant;
   logic [W-1:0]  sa, sb, r;
   logic [CW-1:0] cnt;
   logic          any_vld, accept, bit_z, last_bit;

   xor_bit_cell u_xor_cell (
      .x (sa[0]),
      .y (sb[0]),
      .z (bit_z)
   );

   always_comb begin
      any_vld  = req0_valid | req1_valid;
      // A lone requester wins outright; on a tie the one not served last wins.
      grant    = (req0_valid & req1_valid) ? ~last_id : req1_valid;
      last_bit = (cnt == CW'(W - 1));
      accept   = any_vld & (state == IDLE) & ~rst;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp_valid  = 1'b0;
      case (state)
         IDLE: begin
            if (any_vld) begin
               req0_ready = ~grant;
               req1_ready = grant;
               state_nxt  = RUN;
            end
         end
         RUN: begin
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Reset overrides any handshake in the same cycle.
      if (rst) begin
         req0_ready = 1'b0;
         req1_ready = 1'b0;
         rsp_valid  = 1'b0;
      end
   end

   assign rsp_data = rsp_valid ? r : '0;
   assign rsp_id   = rsp_valid ? id : 1'b0;
   assign busy     = (state != IDLE) & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         sa      <= '0;
         sb      <= '0;
         r       <= '0;
         cnt     <= '0;
         id      <= 1'b0;
         last_id <= ID_RST;
      end else if (accept) begin
         sa      <= grant ? req1_a : req0_a;
         sb      <= grant ? req1_b : req0_b;
         cnt     <= '0;
         id      <= grant;
         last_id <= grant;
      end else if (state == RUN) begin
         // Each result bit enters at the MSB, so bit 0 lands in r[0] after W shifts.
         r   <= (r >> 1) | (W'(bit_z) << (W - 1));
         sa  <= sa >> 1;
         sb  <= sb >> 1;
         cnt <= cnt + CW'(1);
      end
   end
endmodule
